// File: rtl/tt_pkg.sv
// Shared definitions for the truth_table_engine slice.
//   - tt_state_e : engine FSM states (empty table, loading, ready for lookups)
//   - DefaultNIn / DefaultNOut : default input/output widths
//   - depth(n)   : number of table rows for an n-input function
package tt_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StLoad  = 2'd1,
    StReady = 2'd2
  } tt_state_e;

  localparam int unsigned DefaultNIn  = 4;
  localparam int unsigned DefaultNOut = 2;

  function automatic int unsigned depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_table_mem.sv
// Flop-array truth table storage.
//   clk, rst_n : clock, asynchronous active-low clear of every row
//   we         : write enable for row waddr
//   waddr/wdata: write port
//   raddr/rdata: combinational read port
module tt_table_mem
  import tt_pkg::*;
#(
  parameter int unsigned AddrW = DefaultNIn,
  parameter int unsigned DataW = DefaultNOut
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  localparam int unsigned Depth = depth(AddrW);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];

  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/truth_table_engine.sv
// Run-time programmable N_IN-input / N_OUT-output Boolean function unit.
//   load_start              : pulse, (re)starts a table load at row 0
//   cfg_valid/ready/data    : one table row per beat, rows written in order 0..2^N_IN-1
//   in_valid/ready/vec      : lookup request channel
//   out_valid/ready/vec     : one-entry registered result channel
//   table_ok                : a complete load has finished since reset/last reload
module truth_table_engine
  import tt_pkg::*;
#(
  parameter int unsigned N_IN  = DefaultNIn,
  parameter int unsigned N_OUT = DefaultNOut
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_vec,
  output logic             table_ok
);

  // One spare bit so the counter can hold 2^N_IN without aliasing row 0.
  localparam int unsigned        RowW    = N_IN + 1;
  localparam logic [RowW-1:0]    LastRow = RowW'(depth(N_IN) - 1);

  tt_state_e        state_q, state_d;
  logic [RowW-1:0]  row_q, row_d;
  logic             table_ok_q, table_ok_d;
  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_vec_q, out_vec_d;

  logic             mem_we;
  logic [N_OUT-1:0] rd_data;
  logic             cfg_fire;
  logic             in_fire;

  // Ready signals depend only on state and the output stage, never on the valids.
  assign cfg_ready = (state_q == StLoad);
  assign in_ready  = (state_q == StReady) && (!out_valid_q || out_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  tt_table_mem #(
    .AddrW (N_IN),
    .DataW (N_OUT)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (row_q[N_IN-1:0]),
    .wdata (cfg_data),
    .raddr (in_vec),
    .rdata (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    table_ok_d  = table_ok_q;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    mem_we      = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (load_start) begin
          state_d = StLoad;
          row_d   = '0;
        end
      end
      StLoad: begin
        // A restart takes priority over a beat presented in the same cycle.
        if (load_start) begin
          row_d = '0;
        end else if (cfg_fire) begin
          mem_we = 1'b1;
          if (row_q == LastRow) begin
            state_d    = StReady;
            table_ok_d = 1'b1;
            row_d      = '0;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      StReady: begin
        if (load_start) begin
          state_d    = StLoad;
          row_d      = '0;
          table_ok_d = 1'b0;
        end
      end
      default: begin
        state_d = StEmpty;
        row_d   = '0;
      end
    endcase

    // Output stage: accept overrides consume, giving bubble-free back-to-back results.
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_vec_d   = rd_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      row_q       <= '0;
      table_ok_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      table_ok_q  <= table_ok_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign table_ok  = table_ok_q;

endmodule

// File: tb/tb_truth_table_engine.sv
// Bench for truth_table_engine: three instances (4/2, 1/1, 8/16) checked against a
// row-array model of the table and a queue of results still owed downstream.
module tb_truth_table_engine;

  logic clk;
  logic rst_n;

  logic        ls   [3];
  logic        cv   [3];
  logic [15:0] cd   [3];
  logic        iv   [3];
  logic [7:0]  ivec [3];
  logic        ordy [3];

  logic        cr   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [15:0] ovec [3];
  logic        tok  [3];

  logic        cr0, ir0, ov0, tok0;
  logic        cr1, ir1, ov1, tok1;
  logic        cr2, ir2, ov2, tok2;
  logic [1:0]  ovec0;
  logic [0:0]  ovec1;
  logic [15:0] ovec2;

  int          nin  [3] = '{4, 1, 8};
  int          nout [3] = '{2, 1, 16};

  logic [15:0] tbl [3][256];
  logic [15:0] q [$];
  int          total = 0;
  int          bad   = 0;
  int          npop  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  truth_table_engine #(.N_IN(4), .N_OUT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .load_start(ls[0]), .cfg_valid(cv[0]), .cfg_ready(cr0),
    .cfg_data(cd[0][1:0]), .in_valid(iv[0]), .in_ready(ir0), .in_vec(ivec[0][3:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_vec(ovec0), .table_ok(tok0)
  );

  truth_table_engine #(.N_IN(1), .N_OUT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_start(ls[1]), .cfg_valid(cv[1]), .cfg_ready(cr1),
    .cfg_data(cd[1][0:0]), .in_valid(iv[1]), .in_ready(ir1), .in_vec(ivec[1][0:0]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_vec(ovec1), .table_ok(tok1)
  );

  truth_table_engine #(.N_IN(8), .N_OUT(16)) u2 (
    .clk(clk), .rst_n(rst_n), .load_start(ls[2]), .cfg_valid(cv[2]), .cfg_ready(cr2),
    .cfg_data(cd[2]), .in_valid(iv[2]), .in_ready(ir2), .in_vec(ivec[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .out_vec(ovec2), .table_ok(tok2)
  );

  assign cr[0] = cr0;  assign ir[0] = ir0;  assign ov[0] = ov0;  assign tok[0] = tok0;
  assign cr[1] = cr1;  assign ir[1] = ir1;  assign ov[1] = ov1;  assign tok[1] = tok1;
  assign cr[2] = cr2;  assign ir[2] = ir2;  assign ov[2] = ov2;  assign tok[2] = tok2;
  assign ovec[0] = {14'b0, ovec0};
  assign ovec[1] = {15'b0, ovec1};
  assign ovec[2] = ovec2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] omask(input int k);
    return 16'((32'd1 << nout[k]) - 1);
  endfunction

  function automatic logic [7:0] vmask(input int k);
    return 8'((32'd1 << nin[k]) - 1);
  endfunction

  // Reference table from the lab example: f0 = sum m(1,2,3,6,11,12,14,15), f1 = sum m(0,5,10,15).
  function automatic logic [15:0] spec_row(input int r);
    logic b0, b1;
    b0 = r inside {1, 2, 3, 6, 11, 12, 14, 15};
    b1 = r inside {0, 5, 10, 15};
    return {14'b0, b1, b0};
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      ls[k] = 1'b0; cv[k] = 1'b0; cd[k] = '0; iv[k] = 1'b0; ivec[k] = '0; ordy[k] = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 256; r++) tbl[k][r] = '0;
    end
    q.delete();
  endtask

  task automatic check_all_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_cfg_ready"}, {31'b0, cr[k]}, 0);
      chk({tag, "_in_ready"},  {31'b0, ir[k]}, 0);
      chk({tag, "_out_valid"}, {31'b0, ov[k]}, 0);
      chk({tag, "_out_vec"},   {16'b0, ovec[k]}, 0);
      chk({tag, "_table_ok"},  {31'b0, tok[k]}, 0);
    end
  endtask

  // Asynchronous reset asserted between clock edges, outputs checked before any edge.
  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check_all_reset("async_rst");
    clear_inputs();
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One lookup-channel cycle; rdy_st says whether the model believes the engine is READY.
  task automatic step(input int k, input bit v, input logic [7:0] vec, input bit r,
                      input bit rdy_st);
    bit accept;
    iv[k] = v; ivec[k] = vec & vmask(k); ordy[k] = r;
    #2;
    accept = v && rdy_st && (q.size() == 0 || r);
    chk("out_valid", {31'b0, ov[k]}, {31'b0, q.size() != 0});
    chk("in_ready", {31'b0, ir[k]}, {31'b0, rdy_st && (q.size() == 0 || r)});
    if (q.size() != 0) begin
      if (r) begin
        chk("out_vec", {16'b0, ovec[k]}, {16'b0, q.pop_front()});
        npop++;
      end else begin
        chk("out_hold", {16'b0, ovec[k]}, {16'b0, q[0]});
      end
    end
    if (accept) q.push_back(tbl[k][vec & vmask(k)]);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k);
    int guard = 0;
    while (q.size() != 0 && guard < 20) begin
      step(k, 1'b0, 8'd0, 1'b1, 1'b1);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
    iv[k] = 1'b0;
  endtask

  task automatic rand_stream(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      step(k, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0, 1'b1);
    end
    drain(k);
  endtask

  // Loads a full table; abort_at >= 0 re-pulses load_start after that many beats.
  task automatic load(input int k, input bit start, input bit use_spec, input int abort_at);
    int rows;
    int beat;
    int ab;
    logic [15:0] d;
    rows = 1 << nin[k];
    beat = 0;
    ab   = abort_at;
    if (start) begin
      ls[k] = 1'b1;
      tick();
      ls[k] = 1'b0;
    end
    ordy[k] = 1'b0;
    while (beat < rows) begin
      chk("load_cfg_ready", {31'b0, cr[k]}, 1);
      chk("load_in_ready",  {31'b0, ir[k]}, 0);
      chk("load_table_ok",  {31'b0, tok[k]}, 0);
      chk("load_out_valid", {31'b0, ov[k]}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("load_held_vec", {16'b0, ovec[k]}, {16'b0, q[0]});
      iv[k]   = 1'b1;
      ivec[k] = 8'($urandom) & vmask(k);
      if (beat == ab) begin
        ab = -1;
        beat = 0;
        cv[k] = 1'b0;
        ls[k] = 1'b1;
        tick();
        ls[k] = 1'b0;
      end else begin
        cv[k] = $urandom_range(0, 3) != 0;
        d = use_spec ? spec_row(beat) : (16'($urandom) & omask(k));
        cd[k] = d;
        if (cv[k]) begin
          tbl[k][beat] = d;
          beat++;
        end
        tick();
      end
    end
    cv[k] = 1'b0;
    iv[k] = 1'b0;
    chk("load_done_table_ok", {31'b0, tok[k]}, 1);
    chk("load_done_cfg_ready", {31'b0, cr[k]}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    clear_model();
    #3;
    check_all_reset("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // EMPTY: lookups blocked, cfg beats ignored.
    iv[0] = 1'b1; cv[0] = 1'b1; cd[0] = 16'h3;
    tick();
    tick();
    chk("empty_in_ready", {31'b0, ir[0]}, 0);
    chk("empty_cfg_ready", {31'b0, cr[0]}, 0);
    chk("empty_table_ok", {31'b0, tok[0]}, 0);
    clear_inputs();

    // Lab table, then directed lookups with literal expectations.
    load(0, 1'b1, 1'b1, -1);
    step(0, 1'b1, 8'd3, 1'b1, 1'b1);
    chk("lookup_3", {16'b0, ovec[0]}, 32'h1);
    step(0, 1'b1, 8'd15, 1'b1, 1'b1);
    chk("lookup_15", {16'b0, ovec[0]}, 32'h3);
    step(0, 1'b1, 8'd4, 1'b1, 1'b1);
    chk("lookup_4", {16'b0, ovec[0]}, 32'h0);
    drain(0);

    // Backpressure: first request held for 3 cycles, then all five stream out in order.
    npop = 0;
    step(0, 1'b1, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 8'd5, 1'b0, 1'b1);
    chk("bp_held_vec", {16'b0, ovec[0]}, 32'h2);
    step(0, 1'b1, 8'd5, 1'b1, 1'b1);
    step(0, 1'b1, 8'd10, 1'b1, 1'b1);
    step(0, 1'b1, 8'd15, 1'b1, 1'b1);
    step(0, 1'b1, 8'd6, 1'b1, 1'b1);
    drain(0);
    chk("bp_count", npop, 5);

    rand_stream(0, 60);

    // Restart after 7 beats; a premature table_ok would trip load_table_ok.
    load(0, 1'b1, 1'b0, 7);
    rand_stream(0, 40);

    // load_start together with a lookup: accepted from the old table, held through the reload.
    ls[0] = 1'b1;
    step(0, 1'b1, 8'd9, 1'b0, 1'b1);
    ls[0] = 1'b0;
    chk("reload_table_ok", {31'b0, tok[0]}, 0);
    load(0, 1'b0, 1'b0, -1);
    step(0, 1'b0, 8'd0, 1'b0, 1'b1);
    drain(0);
    rand_stream(0, 40);

    // Parameter corners.
    load(1, 1'b1, 1'b0, -1);
    rand_stream(1, 40);
    load(2, 1'b1, 1'b0, -1);
    rand_stream(2, 300);

    // Reset in the middle of a pending handshake.
    step(2, 1'b1, 8'd255, 1'b0, 1'b1);
    step(2, 1'b1, 8'd17, 1'b0, 1'b1);
    reset_mid();
    tick();
    check_all_reset("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
